// File: rtl/cpu_bus_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_decoder_if
//  Brief    : CPU memory port and region select/handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_bus_decoder_if #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int REGION_BITS   = 3
);
    localparam int c_N = 1 << REGION_BITS;

    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic                     cpu_mem_valid;
    logic [3:0]               cpu_wstrb;
    logic [c_N-1:0]           region_ready;
    logic [c_N-1:0]           region_en;
    logic [c_N-1:0]           region_write_en;
    logic                     cpu_mem_ready;
    logic                     bus_error;
    logic [ADDRESS_WIDTH-1:0] error_address;

    // Everything outside the decoder: the CPU plus the peripheral handshakes.
    modport master (
        output cpu_address, cpu_mem_valid, cpu_wstrb, region_ready,
        input  region_en, region_write_en, cpu_mem_ready, bus_error, error_address
    );

    modport slave (
        input  cpu_address, cpu_mem_valid, cpu_wstrb, region_ready,
        output region_en, region_write_en, cpu_mem_ready, bus_error, error_address
    );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_decoder
//  Brief    : Registered region decoder / ready generator with bus error.
//             Define CPU_BUS_DECODER_TIMEOUT_EN to enable the handshake watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_decoder #(
    parameter int                             ADDRESS_WIDTH    = 24,
    parameter int                             REGION_BITS      = 3,
    parameter logic [(1<<REGION_BITS)-1:0]    REGION_MAP       = '1,
    parameter logic [(1<<REGION_BITS)-1:0]    REGION_HANDSHAKE = '0,
    parameter logic [4*(1<<REGION_BITS)-1:0]  REGION_WAIT      = '0,
    parameter int                             TIMEOUT_CYCLES   = 255
) (
    input  logic              clk,
    input  logic              reset,
    cpu_bus_decoder_if.slave  bus
);
    localparam int c_N = 1 << REGION_BITS;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cpu_bus_decoder: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [REGION_BITS-1:0]   region_q, region_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic [3:0]               wait_q, wait_d;
    logic [c_N-1:0]           region_en_q, region_en_d;
    logic [c_N-1:0]           region_write_en_q, region_write_en_d;
    logic                     cpu_mem_ready_q, cpu_mem_ready_d;
    logic                     bus_error_q, bus_error_d;
    logic [ADDRESS_WIDTH-1:0] error_address_q, error_address_d;
    logic [REGION_BITS-1:0]   w_req_region;
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
    localparam logic [15:0]   c_TIMEOUT_M1 = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]              watchdog_q, watchdog_d;
`endif

    assign w_req_region = bus.cpu_address[ADDRESS_WIDTH-1 -: REGION_BITS];

    always_comb begin
        state_d         = state_q;
        region_d        = region_q;
        addr_d          = addr_q;
        wstrb_d         = wstrb_q;
        wait_d          = wait_q;
        error_address_d = error_address_q;
        bus_error_d     = 1'b0;
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
        watchdog_d      = watchdog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_mem_valid) begin
                    region_d = w_req_region;
                    addr_d   = bus.cpu_address;
                    wstrb_d  = bus.cpu_wstrb;
                    if (REGION_MAP[w_req_region]) begin
                        state_d = ST_ACCESS;
                        wait_d  = REGION_WAIT[{w_req_region, 2'b00} +: 4];
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
                        watchdog_d = 16'd0;
`endif
                    end else begin
                        state_d         = ST_DONE;
                        bus_error_d     = 1'b1;
                        error_address_d = bus.cpu_address;
                    end
                end
            end
            ST_ACCESS: begin
                if (!bus.cpu_mem_valid) begin
                    state_d = ST_IDLE;
                end else if (REGION_HANDSHAKE[region_q]) begin
                    // Ready is tested first so it beats a simultaneous timeout.
                    if (bus.region_ready[region_q]) begin
                        state_d = ST_DONE;
                    end
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
                    else if (watchdog_q == c_TIMEOUT_M1) begin
                        state_d         = ST_DONE;
                        bus_error_d     = 1'b1;
                        error_address_d = addr_q;
                    end else begin
                        watchdog_d = watchdog_q + 16'd1;
                    end
`endif
                end else if (wait_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so every port is a flop.
        region_en_d       = '0;
        region_write_en_d = '0;
        if (state_d == ST_ACCESS || (state_d == ST_DONE && state_q == ST_ACCESS)) begin
            region_en_d = c_N'(1) << region_d;
        end
        if (wstrb_d != 4'd0) begin
            region_write_en_d = region_en_d;
        end
        cpu_mem_ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            region_q          <= '0;
            addr_q            <= '0;
            wstrb_q           <= '0;
            wait_q            <= '0;
            region_en_q       <= '0;
            region_write_en_q <= '0;
            cpu_mem_ready_q   <= 1'b0;
            bus_error_q       <= 1'b0;
            error_address_q   <= '0;
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
            watchdog_q        <= '0;
`endif
        end else begin
            state_q           <= state_d;
            region_q          <= region_d;
            addr_q            <= addr_d;
            wstrb_q           <= wstrb_d;
            wait_q            <= wait_d;
            region_en_q       <= region_en_d;
            region_write_en_q <= region_write_en_d;
            cpu_mem_ready_q   <= cpu_mem_ready_d;
            bus_error_q       <= bus_error_d;
            error_address_q   <= error_address_d;
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
            watchdog_q        <= watchdog_d;
`endif
        end
    end

    assign bus.region_en       = region_en_q;
    assign bus.region_write_en = region_write_en_q;
    assign bus.cpu_mem_ready   = cpu_mem_ready_q;
    assign bus.bus_error       = bus_error_q;
    assign bus.error_address   = error_address_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_bus_decoder
//  Brief    : Self-checking bench for cpu_bus_decoder against a cycle-count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_decoder;
    localparam int          C_TIMEOUT = 16;
    localparam logic [7:0]  C_MAP     = 8'h0F;
    localparam logic [7:0]  C_HS      = 8'h04;
    localparam logic [31:0] C_WAIT    = 32'h7654_5030;

    // Region table: regions 0..3 mapped, region 2 handshake, per-region waits.
    bit mapped_tbl [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit hs_tbl     [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    int wait_tbl   [8] = '{0, 3, 0, 5, 4, 5, 6, 7};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_bus_decoder_if #(.ADDRESS_WIDTH(24), .REGION_BITS(3)) bus ();

    cpu_bus_decoder #(
        .ADDRESS_WIDTH   (24),
        .REGION_BITS     (3),
        .REGION_MAP      (C_MAP),
        .REGION_HANDSHAKE(C_HS),
        .REGION_WAIT     (C_WAIT),
        .TIMEOUT_CYCLES  (C_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [23:0] exp_err_addr = '0;

    int          o_rdy_cyc, o_rdy_cnt, o_err_cnt, o_en_first, o_en_last, o_en_cnt;
    logic        o_err_at_rdy;
    logic [7:0]  o_en_or, o_wen_or;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // Expected completion cycle (0 = never), error flag and enable patterns.
    task automatic model_access(input logic [23:0] a, input logic [3:0] s, input int hs,
                                output int e_rdy, output bit e_err,
                                output logic [7:0] e_oh, output logic [7:0] e_woh);
        int r;
        r     = int'(a[23:21]);
        e_err = 1'b0;
        e_oh  = mapped_tbl[r] ? (8'd1 << r) : 8'd0;
        e_woh = (s != 4'd0) ? e_oh : 8'd0;
        if (!mapped_tbl[r]) begin
            e_rdy = 1;
            e_err = 1'b1;
        end else if (!hs_tbl[r]) begin
            e_rdy = wait_tbl[r] + 2;
        end else begin
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
            if (hs >= 1 && hs <= C_TIMEOUT) e_rdy = hs + 1;
            else begin
                e_rdy = C_TIMEOUT + 1;
                e_err = 1'b1;
            end
`else
            e_rdy = (hs >= 1) ? hs + 1 : 0;
`endif
        end
    endtask

    // Drives one access from a negedge, records what the DUT did, returns at a negedge.
    task automatic do_access(input logic [23:0] a, input logic [3:0] s, input int hs, input int mc);
        logic [7:0] oh;
        oh = 8'd1 << a[23:21];
        o_rdy_cyc = 0; o_rdy_cnt = 0; o_err_cnt = 0; o_err_at_rdy = 1'b0;
        o_en_first = 0; o_en_last = 0; o_en_cnt = 0; o_en_or = '0; o_wen_or = '0;
        bus.cpu_address   = a;
        bus.cpu_wstrb     = s;
        bus.cpu_mem_valid = 1'b1;
        bus.region_ready  = 8'($urandom) & ~oh;
        for (int k = 1; k <= mc + 1; k++) begin
            @(negedge clk);
            if (bus.region_en != 8'd0) begin
                if (o_en_first == 0) o_en_first = k;
                o_en_last = k;
                o_en_cnt++;
            end
            o_en_or  |= bus.region_en;
            o_wen_or |= bus.region_write_en;
            if (bus.bus_error) o_err_cnt++;
            if (bus.cpu_mem_ready) begin
                o_rdy_cnt++;
                if (o_rdy_cyc == 0) begin
                    o_rdy_cyc    = k;
                    o_err_at_rdy = bus.bus_error;
                end
            end
            if (o_rdy_cyc != 0 && k == o_rdy_cyc + 1) break;
            if (o_rdy_cyc == k || k == mc) bus.cpu_mem_valid = 1'b0;
            bus.region_ready = 8'($urandom) & ~oh;
            if (k == hs) bus.region_ready = bus.region_ready | oh;
        end
        bus.region_ready = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.region_en, bus.region_write_en, bus.cpu_mem_ready, bus.bus_error, bus.error_address} !== '0) begin
            n_mis++;
            $display("FAIL reset_held: en=%h wen=%h rdy=%b err=%b eaddr=%h, want all 0",
                     bus.region_en, bus.region_write_en, bus.cpu_mem_ready, bus.bus_error, bus.error_address);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.region_en, bus.region_write_en, bus.cpu_mem_ready, bus.bus_error} !== '0) begin
            n_mis++;
            $display("FAIL reset_release: en=%h wen=%h rdy=%b err=%b, want all 0",
                     bus.region_en, bus.region_write_en, bus.cpu_mem_ready, bus.bus_error);
        end
    endtask

    // Runs a list of accesses back to back and compares each against the model.
    task automatic test_accesses(input string nm, input logic [23:0] a [], input logic [3:0] s [],
                                 input int hs [], input int mc);
        int         e_rdy, e_last;
        bit         e_err;
        logic [7:0] e_oh, e_woh;
        for (int i = 0; i < a.size(); i++) begin
            model_access(a[i], s[i], hs[i], e_rdy, e_err, e_oh, e_woh);
            do_access(a[i], s[i], hs[i], mc);
            if (e_err) exp_err_addr = a[i];
            e_last = (e_oh == 8'd0) ? 0 : ((e_rdy > 0) ? e_rdy : mc);
            n_cmp++;
            if (o_rdy_cyc != e_rdy || o_rdy_cnt != ((e_rdy > 0) ? 1 : 0)) begin
                n_mis++;
                $display("FAIL %s[%0d] ready: addr=%h cycle=%0d count=%0d, want cycle=%0d",
                         nm, i, a[i], o_rdy_cyc, o_rdy_cnt, e_rdy);
            end
            n_cmp++;
            if (o_en_first != ((e_oh == 8'd0) ? 0 : 1) || o_en_last != e_last || o_en_cnt != e_last ||
                o_en_or !== e_oh || o_wen_or !== e_woh) begin
                n_mis++;
                $display("FAIL %s[%0d] enables: addr=%h first=%0d last=%0d cnt=%0d en=%h wen=%h, want last=%0d en=%h wen=%h",
                         nm, i, a[i], o_en_first, o_en_last, o_en_cnt, o_en_or, o_wen_or, e_last, e_oh, e_woh);
            end
            n_cmp++;
            if (o_err_cnt != (e_err ? 1 : 0) || o_err_at_rdy !== e_err || bus.error_address !== exp_err_addr) begin
                n_mis++;
                $display("FAIL %s[%0d] error: addr=%h err_cycles=%0d err_at_rdy=%b eaddr=%h, want err=%b eaddr=%h",
                         nm, i, a[i], o_err_cnt, o_err_at_rdy, bus.error_address, e_err, exp_err_addr);
            end
        end
    endtask

    task automatic test_fixed();
        test_accesses("fixed", '{24'h000010, 24'h200000, 24'h6000F0}, '{4'h0, 4'hF, 4'h2}, '{0, 0, 0}, 40);
    endtask

    task automatic test_unmapped();
        test_accesses("unmapped", '{24'hE00004, 24'h800000}, '{4'h0, 4'h1}, '{0, 0}, 40);
    endtask

    task automatic test_handshake();
        test_accesses("handshake", '{24'h400000, 24'h400044, 24'h5FFFFC}, '{4'h0, 4'hC, 4'h0}, '{6, 1, 3}, 40);
    endtask

    task automatic test_timeout();
`ifdef CPU_BUS_DECODER_TIMEOUT_EN
        test_accesses("timeout", '{24'h400100, 24'h400200, 24'h400300}, '{4'h0, 4'h0, 4'h5},
                      '{0, C_TIMEOUT, C_TIMEOUT + 1}, 40);
`else
        test_accesses("no_timeout", '{24'h400100}, '{4'h0}, '{0}, 1000);
`endif
    endtask

    task automatic test_abort();
        int          bad;
        logic [23:0] ea;
        bad = 0;
        ea  = bus.error_address;
        bus.cpu_address = 24'h600010; bus.cpu_wstrb = 4'h0; bus.cpu_mem_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.cpu_mem_valid = 1'b0;
        for (int k = 3; k <= 9; k++) begin
            @(negedge clk);
            if (bus.cpu_mem_ready || bus.bus_error || bus.region_en != 8'd0) bad++;
        end
        n_cmp++;
        if (bad != 0 || bus.error_address !== ea) begin
            n_mis++;
            $display("FAIL abort: bad_cycles=%0d eaddr=%h, want 0 bad cycles and eaddr=%h", bad, bus.error_address, ea);
        end
        test_accesses("after_abort", '{24'h600010}, '{4'h0}, '{0}, 40);
    endtask

    task automatic test_reset_mid();
        bus.cpu_address = 24'h600123; bus.cpu_wstrb = 4'h3; bus.cpu_mem_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.region_en !== 8'h08 || bus.region_write_en !== 8'h08) begin
            n_mis++;
            $display("FAIL reset_mid_pre: en=%h wen=%h, want 08/08", bus.region_en, bus.region_write_en);
        end
        #2 reset = 1'b1;
        #1;
        exp_err_addr = '0;
        n_cmp++;
        if ({bus.region_en, bus.region_write_en, bus.cpu_mem_ready, bus.bus_error, bus.error_address} !== '0) begin
            n_mis++;
            $display("FAIL reset_mid_async: en=%h wen=%h rdy=%b err=%b eaddr=%h, want all 0",
                     bus.region_en, bus.region_write_en, bus.cpu_mem_ready, bus.bus_error, bus.error_address);
        end
        bus.cpu_mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_accesses("after_reset", '{24'h600200, 24'h200008}, '{4'h0, 4'h4}, '{0, 0}, 40);
    endtask

    task automatic test_back_to_back_random();
        logic [23:0] a [];
        logic [3:0]  s [];
        int          hs [];
        a = new[40]; s = new[40]; hs = new[40];
        for (int i = 0; i < 40; i++) begin
            a[i]  = 24'($urandom);
            s[i]  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            hs[i] = $urandom_range(1, 12);
        end
        test_accesses("random", a, s, hs, 40);
    endtask

    initial begin
        bus.cpu_address   = '0;
        bus.cpu_mem_valid = 1'b0;
        bus.cpu_wstrb     = '0;
        bus.region_ready  = '0;
        test_reset();
        test_fixed();
        test_unmapped();
        test_handshake();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_bus_decoder.md
# cpu_bus_decoder

Parametrised, registered CPU bus decoder and ready generator between the CPU memory port and the peripheral/memory regions. It decodes the top address bits into 2^REGION_BITS region selects, holds each access for a per-region fixed wait count or until a peripheral handshake, and returns a single-cycle `cpu_mem_ready`. Unmapped regions and, optionally, stalled handshakes complete with a bus error instead of hanging the CPU.

## Interface
- `ADDRESS_WIDTH`, 24: CPU address bits decoded.
- `REGION_BITS`, 3: region index width; N = 2^REGION_BITS regions.
- `REGION_MAP`, all ones: N-bit mask; bit i = 1 means region i is mapped.
- `REGION_HANDSHAKE`, 0: N-bit mask; bit i = 1 means region i completes on `region_ready[i]`, else on fixed wait count.
- `REGION_WAIT`, 0: 4N bits; region i wait count W_i at [4i+3:4i].
- `TIMEOUT_CYCLES`, 255: handshake watchdog limit (1..65535).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_address` in ADDRESS_WIDTH: byte address.
- `cpu_mem_valid` in 1: access request.
- `cpu_wstrb` in 4: byte write strobes; zero = read.
- `region_ready` in N: per-region completion, used only for handshake regions.
- `region_en` out N: one-hot select of the active region.
- `region_write_en` out N: `region_en` qualified by nonzero latched strobes.
- `cpu_mem_ready` out 1: one-cycle completion pulse.
- `bus_error` out 1: qualifies `cpu_mem_ready` as an error completion.
- `error_address` out ADDRESS_WIDTH: address of the most recent errored access.

## Operation
- Region index r = `cpu_address[ADDRESS_WIDTH-1 -: REGION_BITS]`. r, address and strobes latch on IDLE exit.
- States: IDLE, ACCESS, DONE.
- IDLE: with `cpu_mem_valid`=1 at an edge: if mapped, go ACCESS with wait counter = W_r and watchdog = 0. If unmapped, go DONE with error flag set and no enables.
- ACCESS: `region_en[r]` high, and `region_write_en[r]` if strobes nonzero.
  - Fixed region: counter = 0 → DONE; else decrement.
  - Handshake region: `region_ready[r]` high → DONE. Otherwise watchdog increments.
  - `cpu_mem_valid` low → IDLE, no ready, no error (abort).
- DONE: `cpu_mem_ready`=1 for one cycle. Enables stay asserted for mapped accesses so registered read data is valid. `bus_error` = error flag. Next state is always IDLE.
- The CPU must drop or change `cpu_mem_valid` at the edge ending DONE. IDLE re-samples on the following cycle.
- On an error, `error_address` loads the latched address. It holds until the next error.
- Reset mid-operation: immediately IDLE; all outputs and `error_address` = 0; latched region/address/strobes cleared.

## Timing
- All outputs are registered. No combinational path exists from CPU inputs to outputs.
- Fixed region, wait W: `cpu_mem_valid` sampled at edge E0. Enables are high for cycles 1..W+2. `cpu_mem_ready` is high in cycle W+2.
- Handshake region: `region_ready` sampled at edge Ek during ACCESS. `cpu_mem_ready` is high in the cycle after Ek.
- Unmapped: `cpu_mem_ready` and `bus_error` are both high in cycle 1.
- Maximum throughput: one access per W+3 cycles (IDLE, W+1 ACCESS, DONE).
- `region_ready` for a non-selected region, or outside ACCESS, is ignored.
- `region_ready` arriving on the same edge as the timeout: ready wins, no error.

## Configuration
- `CPU_BUS_DECODER_TIMEOUT_EN` defined: the watchdog is active.
  - A handshake access where watchdog reaches TIMEOUT_CYCLES without `region_ready` → DONE with `bus_error`=1, and `error_address` loads.
- Undefined: the watchdog logic is absent. Handshake accesses wait indefinitely, and `bus_error` asserts only for unmapped regions.

## Test plan
- Set REGION_BITS=3, ADDRESS_WIDTH=24, REGION_WAIT[3:0]=0. Read 24'h000010 → `region_en`=8'h01 for cycles 1–2, `cpu_mem_ready` in cycle 2, `region_write_en`=0, `bus_error`=0.
- Set W_1=3. Write 24'h200000 with strobes 4'hF → `region_en`/`region_write_en`=8'h02 for cycles 1–5, `cpu_mem_ready` in cycle 5.
- Set REGION_MAP=8'h0F. Read 24'hE00004 → `cpu_mem_ready`=`bus_error`=1 in cycle 1, `region_en`=0, `error_address`=24'hE00004.
- Make region 2 a handshake region. Pulse `region_ready`=8'h04 in cycle 6 → `cpu_mem_ready` in cycle 7. A `region_ready`=8'h08 pulse in cycle 3 has no effect.
- With the macro defined and TIMEOUT_CYCLES=16, hold `region_ready` low → error completion after 16 ACCESS cycles. Without the macro, no `cpu_mem_ready` within 1000 cycles.
- Assert `reset` in the middle of ACCESS → all outputs 0 asynchronously. After release, a new access completes normally. Dropping `cpu_mem_valid` in ACCESS gives IDLE with no `cpu_mem_ready`.
